// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg : shared encodings for the multi-cycle RV32-subset controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    EXEC_R   = S_EXEC_R,
    EXEC_I   = S_EXEC_I,
    MEM_ADDR = S_MEM_ADDR,
    MEM_RD   = S_MEM_RD,
    MEM_WR   = S_MEM_WR,
    WB_ALU   = S_WB_ALU,
    WB_MEM   = S_WB_MEM,
`ifdef ILLEGAL_TRAP_EN
    TRAP     = S_TRAP,
`endif
    BRANCH   = S_BRANCH
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/insn_legal_decode.sv
// ---------------------------------------------------------------------------
// insn_legal_decode : classifies opcode/funct3 as legal, load or store
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module insn_legal_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output logic       legal_o,
  output logic       is_load_o,
  output logic       is_store_o
);

  always_comb begin
    legal_o    = 1'b0;
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    case (opcode_i)
      OP_R:      legal_o = (funct3_i == F3_ADD) || (funct3_i == F3_OR) ||
                           (funct3_i == F3_SLL);
      OP_I:      legal_o = (funct3_i == F3_AND);
      OP_LOAD: begin
        legal_o   = (funct3_i == F3_H);
        is_load_o = (funct3_i == F3_H);
      end
      OP_STORE: begin
        legal_o    = (funct3_i == F3_H);
        is_store_o = (funct3_i == F3_H);
      end
      OP_BRANCH: legal_o = (funct3_i == F3_BNE);
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control : main sequencing FSM of the multi-cycle RV32 subset
// Optional feature macro: ILLEGAL_TRAP_EN (illegal decode locks up in TRAP).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] instr_count
);

  state_t      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic        store_q, store_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic        dec_legal;
  logic        dec_is_load;
  logic        dec_is_store;

  insn_legal_decode u_decode (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .legal_o    (dec_legal),
    .is_load_o  (dec_is_load),
    .is_store_o (dec_is_store)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      hold_q        <= 4'(RESET_PC_HOLD);
      store_q       <= 1'b0;
      illegal_q     <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      store_q       <= store_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    store_d    = store_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;

    case (state_q)
      FETCH: begin
        if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
        end else begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
      end
      DECODE: begin
        alu_src_b = SRCB_IMM;
        if (!dec_legal) begin
          illegal_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_d   = TRAP;
`else
          state_d   = FETCH;
`endif
        end else if (dec_is_load || dec_is_store) begin
          store_d = dec_is_store;
          state_d = MEM_ADDR;
        end else if (opcode == OP_R) begin
          state_d = EXEC_R;
        end else if (opcode == OP_I) begin
          state_d = EXEC_I;
        end else begin
          state_d = BRANCH;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        state_d   = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = WB_ALU;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = store_q ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = WB_MEM;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      WB_ALU: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = !zero;
        state_d   = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase

    // Outputs decode from a state that is already FETCH during reset, so gate them here.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if ((state_q != FETCH) && (state_d == FETCH))
      instr_count_d = instr_count_q + 32'd1;
  end

  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control : scoreboard bench for multicycle_control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  localparam int HOLD = 2;

  localparam int T_RST = 0, T_HOLD = 1, T_FETCH = 2, T_DEC = 3, T_EXR = 4,
                 T_EXI = 5, T_MADDR = 6, T_MRD = 7, T_MWR = 8, T_WBA = 9,
                 T_WBM = 10, T_BR = 11, T_TRAP = 12;

  localparam logic [6:0] C_OP_R  = 7'b0110011;
  localparam logic [6:0] C_OP_I  = 7'b0010011;
  localparam logic [6:0] C_OP_LD = 7'b0000011;
  localparam logic [6:0] C_OP_ST = 7'b0100011;
  localparam logic [6:0] C_OP_BR = 7'b1100011;
  localparam logic [6:0] C_OP_LUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, illegal;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_control #(.RESET_PC_HOLD(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .iord        (iord),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  typedef struct {
    string       nm;
    logic [45:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt;
  logic        exp_ill;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, src_b, alu_op, reg_write, mem_to_reg}
  function automatic logic [12:0] exp_ctl(int st, logic mr, logic z);
    case (st)
      T_FETCH: return {1'b1, 1'b0, 1'b0, mr, mr, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
      T_DEC:   return 13'b0_0_0_0_0_0_0_10_00_0_0;
      T_EXR:   return 13'b0_0_0_0_0_0_1_00_10_0_0;
      T_EXI:   return 13'b0_0_0_0_0_0_1_10_10_0_0;
      T_MADDR: return 13'b0_0_0_0_0_0_1_10_00_0_0;
      T_MRD:   return 13'b1_0_1_0_0_0_0_00_00_0_0;
      T_MWR:   return 13'b1_1_1_0_0_0_0_00_00_0_0;
      T_WBA:   return 13'b0_0_0_0_0_0_0_00_00_1_0;
      T_WBM:   return 13'b0_0_0_0_0_0_0_00_00_1_1;
      T_BR:    return {1'b0, 1'b0, 1'b0, 1'b0, !z, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0};
      default: return 13'd0;
    endcase
  endfunction

  logic [45:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, mem_to_reg, illegal, instr_count};

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b ill=%b cnt=%h, want ctl=%b ill=%b cnt=%h",
                 e.nm, act[45:33], act[32], act[31:0], e.v[45:33], e.v[32], e.v[31:0]);
      end
    end
  end

  task automatic insn(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  task automatic step(input string nm, input int st, input logic mr, input logic z,
                      input logic rs, input logic retire, input logic set_ill);
    exp_t e;
    reset     = rs;
    mem_ready = mr;
    zero      = z;
    if (rs) begin
      exp_cnt = 32'd0;
      exp_ill = 1'b0;
    end
    e.nm = nm;
    e.v  = {exp_ctl(st, mr, z), exp_ill, exp_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (retire) exp_cnt = exp_cnt + 32'd1;
    if (set_ill) exp_ill = 1'b1;
  endtask

  task automatic reset_and_hold(input string nm);
    step({nm, "_rst"}, T_RST, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step({nm, "_hold0"}, T_HOLD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step({nm, "_hold1"}, T_HOLD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_add(input string nm);
    insn(C_OP_R, 3'b000);
    step({nm, "_f"},  T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step({nm, "_d"},  T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step({nm, "_x"},  T_EXR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step({nm, "_wb"}, T_WBA,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct3 = '0;
    exp_cnt = 32'd0; exp_ill = 1'b0;
    @(posedge clk); #1;

    step("rst_a", T_RST, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // mem_ready held high during reset and hold: must not start a fetch
    reset_and_hold("boot");

    run_add("add");

    insn(C_OP_R, 3'b110);
    step("or_fwait", T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("or_f",     T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("or_d",     T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("or_x",     T_EXR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("or_wb",    T_WBA,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    insn(C_OP_I, 3'b111);
    step("andi_f",  T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("andi_d",  T_DEC,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("andi_x",  T_EXI,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("andi_wb", T_WBA,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    insn(C_OP_LD, 3'b001);
    step("lh_f",   T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh_d",   T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh_a",   T_MADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh_rd0", T_MRD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh_rd1", T_MRD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh_rd2", T_MRD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh_wb",  T_WBM,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    insn(C_OP_ST, 3'b001);
    step("sh_f",  T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sh_d",  T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sh_a",  T_MADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("sh_wr", T_MWR,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    insn(C_OP_BR, 3'b001);
    step("bne1_f", T_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("bne1_d", T_DEC,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("bne1_b", T_BR,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step("bne0_f", T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("bne0_d", T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("bne0_b", T_BR,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    insn(C_OP_LUI, 3'b000);
    step("ill_f", T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    step("ill_d", T_DEC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("trap0", T_TRAP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("trap1", T_TRAP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("trap2", T_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    step("ill_d", T_DEC,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_add("add_sticky");
    insn(C_OP_R, 3'b010);
    step("illf3_f", T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("illf3_d", T_DEC,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    reset_and_hold("rst2");
    insn(C_OP_LD, 3'b001);
    step("lh2_f",  T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh2_d",  T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh2_a",  T_MADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lh2_rd", T_MRD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_mid", T_RST,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mid_hold0", T_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mid_hold1", T_HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    insn(C_OP_ST, 3'b001);
    step("wrap_f", T_FETCH, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    exp_cnt = 32'hFFFF_FFFF;
    step("wrap_d",  T_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wrap_a",  T_MADDR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wrap_wr", T_MWR,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wrap_f2", T_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
